// File: rtl/mux_ctrl_rr_pkg.sv
// Shared definitions for the mux_ctrl_rr crossbar scheduler.
//   PORT_NUB_TOTAL : default port count
//   MODE_TDM/MODE_RR : scheduling mode encodings
//   width_sel()    : select field width, max(1, clog2(n))
//   inc_mod()      : (val + 1) mod n
package mux_ctrl_rr_pkg;

    localparam int unsigned PORT_NUB_TOTAL = 4;

    localparam int unsigned MODE_TDM = 0;
    localparam int unsigned MODE_RR  = 1;

    function automatic int unsigned width_sel(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned inc_mod(input int unsigned val, input int unsigned n);
        return (val + 1 >= n) ? 0 : val + 1;
    endfunction

endpackage

// File: rtl/mux_ctrl_rr_rr_arbiter.sv
// Combinational rotating-priority arbiter over N requests.
//   req : request vector
//   ptr : highest-priority index; search runs circularly from here
//   gnt : one-hot grant
//   any : some request was granted
//   idx : index of the granted request (0 when none)
module mux_ctrl_rr_rr_arbiter
    import mux_ctrl_rr_pkg::*;
#(
    parameter  int unsigned N = PORT_NUB_TOTAL,
    localparam int unsigned W = width_sel(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic         any,
    output logic [W-1:0] idx
);

    // Outer loop walks the circular priority order; inner loop keeps all
    // indexing constant after unrolling.
    always_comb begin
        gnt = '0;
        any = 1'b0;
        idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned s = 0; s < N; s++) begin
                if (!any && req[s] && ((32'(ptr) + i) % N == s)) begin
                    any    = 1'b1;
                    gnt[s] = 1'b1;
                    idx    = W'(s);
                end
            end
        end
    end

endmodule

// File: rtl/mux_ctrl_rr.sv
// Crossbar scheduler for the shared-memory switch. Computes a conflict-free
// source->destination matching each cycle (TDM rotation or single-iteration
// round-robin request/grant/accept) and issues VOQ reads, then destination
// mux selects and write strobes RD_LAT cycles later.
//   clk, rst  : clock, synchronous active-high reset
//   hold      : stop issuing new reads; in-flight writes still drain
//   empty_in  : bit [s*N+d] set when VOQ s->d is empty
//   full_in   : bit d set when destination d is full
//   rd_out    : per-source read strobe
//   rd_sel    : per-source destination field (valid with rd_out)
//   mux_sel   : per-destination source field (valid with wr_out)
//   wr_out    : per-destination write strobe
module mux_ctrl_rr
    import mux_ctrl_rr_pkg::*;
#(
    parameter  int unsigned PORT_NUB  = PORT_NUB_TOTAL,
    parameter  int unsigned MODE      = MODE_RR,
    parameter  int unsigned RD_LAT    = 1,
    localparam int unsigned WIDTH_SEL = width_sel(PORT_NUB)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            hold,
    input  logic [PORT_NUB*PORT_NUB-1:0]    empty_in,
    input  logic [PORT_NUB-1:0]             full_in,
    output logic [PORT_NUB-1:0]             rd_out,
    output logic [PORT_NUB*WIDTH_SEL-1:0]   rd_sel,
    output logic [PORT_NUB*WIDTH_SEL-1:0]   mux_sel,
    output logic [PORT_NUB-1:0]             wr_out
);

    localparam int unsigned N = PORT_NUB;
    localparam int unsigned W = WIDTH_SEL;

    // req[d][s]: source s wants destination d this cycle
    logic [N-1:0]   req [N];
    logic [N-1:0]   iss_src;
    logic [N-1:0]   iss_dst;
    logic [N*W-1:0] iss_rd_sel;
    logic [N*W-1:0] iss_mux_sel;

    always_comb begin
        for (int unsigned d = 0; d < N; d++) begin
            req[d] = '0;
            for (int unsigned s = 0; s < N; s++) begin
                req[d][s] = !empty_in[s*N+d] && !full_in[d] && !hold;
            end
        end
    end

    if (MODE == MODE_TDM) begin : g_tdm
        logic [W-1:0] cnt_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (!hold) begin
                cnt_q <= W'(inc_mod(32'(cnt_q), N));
            end
        end

        // Destination d pairs with source (d+cnt) mod N: a permutation, so
        // the matching is conflict-free by construction.
        always_comb begin
            iss_src     = '0;
            iss_dst     = '0;
            iss_rd_sel  = '0;
            iss_mux_sel = '0;
            for (int unsigned d = 0; d < N; d++) begin
                for (int unsigned s = 0; s < N; s++) begin
                    if (((d + 32'(cnt_q)) % N == s) && req[d][s]) begin
                        iss_src[s]            = 1'b1;
                        iss_dst[d]            = 1'b1;
                        iss_rd_sel[s*W +: W]  = W'(d);
                        iss_mux_sel[d*W +: W] = W'(s);
                    end
                end
            end
        end
    end else begin : g_rr
        logic [W-1:0] g_q [N];
        logic [W-1:0] a_q [N];
        logic [N-1:0] gnt [N];         // gnt[d] over sources
        logic [N-1:0] gnt_any;
        logic [W-1:0] gnt_idx [N];
        logic [N-1:0] gnt_to_src [N];  // gnt_to_src[s] over destinations
        logic [N-1:0] acc [N];         // acc[s] over destinations
        logic [N-1:0] acc_any;
        logic [W-1:0] acc_idx [N];

        for (genvar d = 0; d < N; d++) begin : g_grant
            mux_ctrl_rr_rr_arbiter #(.N(N)) u_grant (
                .req (req[d]),
                .ptr (g_q[d]),
                .gnt (gnt[d]),
                .any (gnt_any[d]),
                .idx (gnt_idx[d])
            );
        end

        always_comb begin
            for (int unsigned s = 0; s < N; s++) begin
                gnt_to_src[s] = '0;
                for (int unsigned d = 0; d < N; d++) begin
                    gnt_to_src[s][d] = gnt[d][s];
                end
            end
        end

        for (genvar s = 0; s < N; s++) begin : g_accept
            mux_ctrl_rr_rr_arbiter #(.N(N)) u_accept (
                .req (gnt_to_src[s]),
                .ptr (a_q[s]),
                .gnt (acc[s]),
                .any (acc_any[s]),
                .idx (acc_idx[s])
            );
        end

        always_comb begin
            iss_src     = '0;
            iss_dst     = '0;
            iss_rd_sel  = '0;
            iss_mux_sel = '0;
            for (int unsigned s = 0; s < N; s++) begin
                if (acc_any[s]) begin
                    iss_src[s]           = 1'b1;
                    iss_rd_sel[s*W +: W] = acc_idx[s];
                end
                for (int unsigned d = 0; d < N; d++) begin
                    if (acc[s][d]) begin
                        iss_dst[d]            = 1'b1;
                        iss_mux_sel[d*W +: W] = W'(s);
                    end
                end
            end
        end

        // An accepted destination always holds the grant to its source, so
        // gnt_idx[d] is the matched source. Hold zeroes req, freezing pointers.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned i = 0; i < N; i++) begin
                    g_q[i] <= '0;
                    a_q[i] <= '0;
                end
            end else begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (gnt_any[i] && iss_dst[i]) begin
                        g_q[i] <= W'(inc_mod(32'(gnt_idx[i]), N));
                    end
                    if (iss_src[i]) begin
                        a_q[i] <= W'(inc_mod(32'(acc_idx[i]), N));
                    end
                end
            end
        end
    end

    // Issue register drives rd_out and feeds the RD_LAT-stage write delay line.
    logic [N-1:0]   rd_q;
    logic [N*W-1:0] rd_sel_q;
    logic [N-1:0]   wr_pend_q;
    logic [N*W-1:0] mux_pend_q;
    logic [N-1:0]   dly_vld_q [RD_LAT];
    logic [N*W-1:0] dly_sel_q [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q       <= '0;
            rd_sel_q   <= '0;
            wr_pend_q  <= '0;
            mux_pend_q <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                dly_vld_q[i] <= '0;
                dly_sel_q[i] <= '0;
            end
        end else begin
            rd_q         <= iss_src;
            rd_sel_q     <= iss_rd_sel;
            wr_pend_q    <= iss_dst;
            mux_pend_q   <= iss_mux_sel;
            dly_vld_q[0] <= wr_pend_q;
            dly_sel_q[0] <= mux_pend_q;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                dly_vld_q[i] <= dly_vld_q[i-1];
                dly_sel_q[i] <= dly_sel_q[i-1];
            end
        end
    end

    assign rd_out  = rd_q;
    assign rd_sel  = rd_sel_q;
    assign wr_out  = dly_vld_q[RD_LAT-1];
    assign mux_sel = dly_sel_q[RD_LAT-1];

endmodule

// File: tb/tb_mux_ctrl_rr.sv
// Directed bench for mux_ctrl_rr: an RR instance (N=4) and a TDM instance (N=3),
// both with RD_LAT=1.
module tb_mux_ctrl_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // RR instance
    logic        rst_r, hold_r;
    logic [15:0] empty_r;
    logic [3:0]  full_r, rd_r, wr_r;
    logic [7:0]  rd_sel_r, mux_r;

    // TDM instance
    logic        rst_t, hold_t;
    logic [8:0]  empty_t;
    logic [2:0]  full_t, rd_t, wr_t;
    logic [5:0]  rd_sel_t, mux_t;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt;
    logic [5:0] exp_rs, exp_ms, prev_ms;

    mux_ctrl_rr #(.PORT_NUB(4), .MODE(1), .RD_LAT(1)) dut_rr (
        .clk      (clk),
        .rst      (rst_r),
        .hold     (hold_r),
        .empty_in (empty_r),
        .full_in  (full_r),
        .rd_out   (rd_r),
        .rd_sel   (rd_sel_r),
        .mux_sel  (mux_r),
        .wr_out   (wr_r)
    );

    mux_ctrl_rr #(.PORT_NUB(3), .MODE(0), .RD_LAT(1)) dut_tdm (
        .clk      (clk),
        .rst      (rst_t),
        .hold     (hold_t),
        .empty_in (empty_t),
        .full_in  (full_t),
        .rd_out   (rd_t),
        .rd_sel   (rd_sel_t),
        .mux_sel  (mux_t),
        .wr_out   (wr_t)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rr_reset();
        rst_r   = 1'b1;
        empty_r = '1;
        tick();
        tick();
        rst_r   = 1'b0;
    endtask

    task automatic tdm_expect(input int c);
        for (int s = 0; s < 3; s++) begin
            exp_rs[2*s +: 2] = 2'((s + 3 - c) % 3);
            exp_ms[2*s +: 2] = 2'((s + c) % 3);
        end
    endtask

    initial begin
        rst_r = 1'b1; hold_r = 1'b0; empty_r = '0; full_r = '0;
        rst_t = 1'b1; hold_t = 1'b0; empty_t = '0; full_t = '0;

        // Reset with every VOQ non-empty
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_rd", 32'(rd_r), 32'h0);
            check_eq("rst_wr", 32'(wr_r), 32'h0);
            check_eq("rst_mux", 32'(mux_r), 32'h0);
        end
        rst_r = 1'b0;
        tick();
        check_eq("rel1_rd", 32'(rd_r), 32'h1);
        check_eq("rel1_rd_sel", 32'(rd_sel_r), 32'h0);
        check_eq("rel1_wr", 32'(wr_r), 32'h0);
        check_eq("rel1_mux", 32'(mux_r), 32'h0);
        tick();
        check_eq("rel2_rd", 32'(rd_r), 32'h3);
        check_eq("rel2_rd_sel", 32'(rd_sel_r), 32'h01);
        check_eq("rel2_wr", 32'(wr_r), 32'h1);
        check_eq("rel2_mux", 32'(mux_r), 32'h0);

        // Single flow 2->1
        rr_reset();
        empty_r[9] = 1'b0;
        tick();
        check_eq("flow_rd", 32'(rd_r), 32'h4);
        check_eq("flow_rd_sel", 32'(rd_sel_r), 32'h10);
        check_eq("flow_wr0", 32'(wr_r), 32'h0);
        tick();
        check_eq("flow_wr", 32'(wr_r), 32'h2);
        check_eq("flow_mux", 32'(mux_r), 32'h08);
        check_eq("flow_rd2", 32'(rd_r), 32'h4);

        // Contention: sources 0 and 1 both want destination 3
        rr_reset();
        empty_r[3] = 1'b0;
        empty_r[7] = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            check_eq("cont_rd", 32'(rd_r), (c % 2 == 1) ? 32'h1 : 32'h2);
            check_eq("cont_rd_sel", 32'(rd_sel_r), (c % 2 == 1) ? 32'h03 : 32'h0c);
            if (c > 1) begin
                check_eq("cont_wr", 32'(wr_r), 32'h8);
                check_eq("cont_mux", 32'(mux_r), (c % 2 == 0) ? 32'h0 : 32'h40);
            end
        end

        // Destination 3 full for 5 cycles; last issue (source 1) drains
        full_r[3] = 1'b1;
        for (int c = 7; c <= 11; c++) begin
            tick();
            check_eq("full_rd", 32'(rd_r), 32'h0);
            check_eq("full_wr", 32'(wr_r), (c == 7) ? 32'h8 : 32'h0);
            check_eq("full_mux", 32'(mux_r), (c == 7) ? 32'h40 : 32'h0);
        end
        full_r[3] = 1'b0;
        tick();
        check_eq("resume_rd", 32'(rd_r), 32'h1);
        check_eq("resume_rd_sel", 32'(rd_sel_r), 32'h03);
        tick();
        check_eq("resume_rd2", 32'(rd_r), 32'h2);
        check_eq("resume_wr", 32'(wr_r), 32'h8);
        check_eq("resume_mux", 32'(mux_r), 32'h0);

        // RR hold for 4 cycles
        hold_r = 1'b1;
        for (int c = 14; c <= 17; c++) begin
            tick();
            check_eq("rr_hold_rd", 32'(rd_r), 32'h0);
            check_eq("rr_hold_wr", 32'(wr_r), (c == 14) ? 32'h8 : 32'h0);
            check_eq("rr_hold_mux", 32'(mux_r), (c == 14) ? 32'h40 : 32'h0);
        end
        hold_r = 1'b0;
        tick();
        check_eq("rr_unhold_rd", 32'(rd_r), 32'h1);
        check_eq("rr_unhold_wr", 32'(wr_r), 32'h0);
        tick();
        check_eq("rr_unhold_rd2", 32'(rd_r), 32'h2);
        check_eq("rr_unhold_mux", 32'(mux_r), 32'h0);

        // TDM permutation, N=3, all VOQs non-empty
        rst_t   = 1'b0;
        exp_cnt = 0;
        prev_ms = '0;
        for (int j = 1; j <= 7; j++) begin
            tick();
            tdm_expect(exp_cnt);
            check_eq("tdm_rd", 32'(rd_t), 32'h7);
            check_eq("tdm_rd_sel", 32'(rd_sel_t), 32'(exp_rs));
            if (j > 1) begin
                check_eq("tdm_wr", 32'(wr_t), 32'h7);
                check_eq("tdm_mux", 32'(mux_t), 32'(prev_ms));
            end
            prev_ms = exp_ms;
            exp_cnt = (exp_cnt + 1) % 3;
        end

        // TDM hold for 4 cycles; pending write still pulses
        hold_t = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("tdm_hold_rd", 32'(rd_t), 32'h0);
            check_eq("tdm_hold_wr", 32'(wr_t), (k == 0) ? 32'h7 : 32'h0);
            check_eq("tdm_hold_mux", 32'(mux_t), (k == 0) ? 32'(prev_ms) : 32'h0);
        end
        hold_t = 1'b0;
        tick();
        tdm_expect(exp_cnt);
        check_eq("tdm_unhold_rd", 32'(rd_t), 32'h7);
        check_eq("tdm_unhold_rd_sel", 32'(rd_sel_t), 32'(exp_rs));
        tick();
        check_eq("tdm_unhold_mux", 32'(mux_t), 32'(exp_ms));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
